// File: rtl/hicore_redirect_ctrl.sv
// Fetch-redirect controller: funnels branch and trap redirects to the fetch unit.
// Latency: request in cycle N -> redir_valid and flush in cycle N+1.
// Backpressure: redir_pc is held while fetch_ready=0; new branches are ignored until the
// redirect completes and the wrong-path shadow expires; traps always replace a pending one.
// Optional build macro HICORE_REDIR_CNT_EN enables the redir_cnt/trap_cnt counters;
// without it both ports are tied to zero.
module hicore_redirect_ctrl #(
  parameter int PC_W   = 32,
  parameter int SHADOW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_pc,
  input  logic            fetch_ready,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic            flush,
  output logic            busy,
  output logic [31:0]     redir_cnt,
  output logic [31:0]     trap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_SHADOW = 2'd2
  } state_t;

  // Shadow counter start value; the SHADOW state is left once the count reaches 1 or 0,
  // so the wrong-path window after a handshake lasts max(1, SHADOW-1) cycles.
  localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW - 1);

  state_t     state;
  logic [2:0] shadow_cnt;
  logic       br_req;

  assign br_req = br_valid & br_taken;

  // Redirect FSM with registered outputs; traps win over branches and over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      shadow_cnt  <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trap_valid || br_req) begin
            redir_pc    <= trap_valid ? trap_pc : br_pc;
            state       <= S_REQ;
            redir_valid <= 1'b1;
            busy        <= 1'b1;
            flush       <= 1'b1;
          end
        end
        S_REQ: begin
          if (trap_valid) begin
            redir_pc <= trap_pc;
            flush    <= 1'b1;
          end else if (fetch_ready) begin
            state       <= S_SHADOW;
            redir_valid <= 1'b0;
            shadow_cnt  <= SHADOW_LOAD;
          end
        end
        S_SHADOW: begin
          if (trap_valid) begin
            redir_pc    <= trap_pc;
            state       <= S_REQ;
            redir_valid <= 1'b1;
            flush       <= 1'b1;
            shadow_cnt  <= '0;
          end else if (shadow_cnt <= 3'd1) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            shadow_cnt <= '0;
          end else begin
            shadow_cnt <= shadow_cnt - 3'd1;
          end
        end
        default: begin
          state       <= S_IDLE;
          redir_valid <= 1'b0;
          busy        <= 1'b0;
          shadow_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef HICORE_REDIR_CNT_EN
  logic handshake;

  // A handshake completes only when no trap overrides it in the same cycle.
  assign handshake = (state == S_REQ) & fetch_ready & ~trap_valid;

  // Event counters; every trap is captured in every state, so each one counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt <= '0;
      trap_cnt  <= '0;
    end else begin
      if (handshake)  redir_cnt <= redir_cnt + 32'd1;
      if (trap_valid) trap_cnt  <= trap_cnt + 32'd1;
    end
  end
`else
  assign redir_cnt = '0;
  assign trap_cnt  = '0;
`endif

endmodule

// File: tb/tb_hicore_redirect_ctrl.sv
// Bench for hicore_redirect_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
// Counter expectations follow the HICORE_REDIR_CNT_EN build macro.
module tb_hicore_redirect_ctrl;

  localparam int SHADOW = 2;
`ifdef HICORE_REDIR_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        fetch_ready = 1'b0;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        flush;
  logic        busy;
  logic [31:0] redir_cnt;
  logic [31:0] trap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a pending redirect, how many wrong-path cycles remain, event tallies.
  bit          m_pending;
  int          m_shadow_left;
  logic [31:0] m_pc;
  bit          m_flush;
  logic [31:0] m_redirs;
  logic [31:0] m_traps;

  hicore_redirect_ctrl #(.PC_W(32), .SHADOW(SHADOW)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc),
    .fetch_ready (fetch_ready),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .flush       (flush),
    .busy        (busy),
    .redir_cnt   (redir_cnt),
    .trap_cnt    (trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_pending = 0; m_shadow_left = 0; m_pc = '0; m_flush = 0;
      m_redirs = '0; m_traps = '0;
    end else begin
      m_flush = 0;
      if (trap_valid) begin
        m_pc = trap_pc; m_pending = 1; m_shadow_left = 0; m_flush = 1;
        m_traps = m_traps + 32'(CNT_ON);
      end else if (m_pending) begin
        if (fetch_ready) begin
          m_pending = 0;
          m_shadow_left = (SHADOW > 1) ? SHADOW - 1 : 1;
          m_redirs = m_redirs + 32'(CNT_ON);
        end
      end else if (m_shadow_left > 0) begin
        m_shadow_left--;
      end else if (br_valid && br_taken) begin
        m_pc = br_pc; m_pending = 1; m_flush = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("redir_valid", 32'(redir_valid), 32'(m_pending));
    chk("redir_pc", redir_pc, m_pc);
    chk("flush", 32'(flush), 32'(m_flush));
    chk("busy", 32'(busy), 32'(m_pending || m_shadow_left > 0));
    chk("redir_cnt", redir_cnt, m_redirs);
    chk("trap_cnt", trap_cnt, m_traps);
  endtask

  // Apply one cycle of inputs, clock it, then compare shortly after the edge.
  task automatic step(input logic r, input logic bv, input logic bt, input logic [31:0] bp,
                      input logic tv, input logic [31:0] tp, input logic fr);
    rst = r; br_valid = bv; br_taken = bt; br_pc = bp;
    trap_valid = tv; trap_pc = tp; fetch_ready = fr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_cycle(input logic fr);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, fr);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    // Reset state; a same-cycle request must not survive reset.
    step(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 32'h5678, 1'b1);
    chk("rst_valid", 32'(redir_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pc", redir_pc, 32'h0);

    // Branch with immediate acceptance, then a branch in the shadow cycle.
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    chk("b034_valid", 32'(redir_valid), 32'h1);
    chk("b034_pc", redir_pc, 32'h100);
    chk("b034_flush", 32'(flush), 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'hdead, 1'b0, 32'h0, 1'b1);
    chk("b034_shadow_valid", 32'(redir_valid), 32'h0);
    chk("b034_shadow_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
    chk("b036_idle_busy", 32'(busy), 32'h0);
    chk("b036_flush", 32'(flush), 32'h0);
    chk("b036_redir_cnt", redir_cnt, 32'(CNT_ON));

    // Stalled branch overridden by a trap in its second REQ cycle.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h250, 1'b0, 32'h0, 1'b0);
    chk("b035_hold_pc", redir_pc, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
    chk("b035_trap_pc", redir_pc, 32'h8000_0000);
    chk("b035_reflush", 32'(flush), 32'h1);
    idle_cycle(1'b1);
    chk("b035_redir_cnt", redir_cnt, 32'(CNT_ON));
    chk("b035_trap_cnt", trap_cnt, 32'(CNT_ON));
    idle_cycle(1'b0);

    // Trap and branch in the same idle cycle: trap wins.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400, 1'b0);
    chk("b037_pc", redir_pc, 32'h400);
    chk("b037_trap_cnt", trap_cnt, 32'(CNT_ON));

    // Reset while a redirect is pending drops it; a later branch is served normally.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
    chk("b038_pending_pc", redir_pc, 32'h600);
    step(1'b1, 1'b1, 1'b1, 32'h999, 1'b0, 32'h0, 1'b1);
    chk("b038_rst_valid", 32'(redir_valid), 32'h0);
    chk("b038_rst_pc", redir_pc, 32'h0);
    chk("b038_rst_cnt", redir_cnt, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    chk("b038_new_pc", redir_pc, 32'h700);
    chk("b038_new_valid", 32'(redir_valid), 32'h1);
    idle_cycle(1'b1);
    chk("b038_new_cnt", redir_cnt, 32'(CNT_ON));

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom), 1'($urandom), $urandom,
           ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
